karatsuba_mult_pipe: RTL and testbench

Parametrised, fully pipelined Karatsuba multiplier. Successor to the single-cycle 64-bit Karatsuba block: generic operand width, fixed 3-stage latency, valid/ready handshake with backpressure, exact full-width product. Sits between the operand-formatting logic and the accumulator in the multiplier datapath. Sustains one multiply per clock when not stalled.

---
 rtl/karatsuba_mult_pipe.sv | 167 ++++++++++++++++
 tb/tb_karatsuba_mult_pipe.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/karatsuba_mult_pipe.sv
// Purpose : fully pipelined Karatsuba multiplier, exact 2*WIDTH-bit product of x*y.
// Latency : 3 stages (S1 split/pre-add, S2 partial products, S3 recombine); one op per clock.
// Backpr. : global stall; all stages hold while out_valid && !out_ready, in_ready drops.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready = pipeline advance)
//   x, y                  WIDTH-bit operands
//   out_valid / out_ready product handshake
//   product               2*WIDTH-bit result, held stable while stalled
//
// Build option: define KMUL_SIGNED_EN to add the is_signed input (two's complement
// operands when set). Without it the block is unsigned only.
module karatsuba_mult_pipe #(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
`ifdef KMUL_SIGNED_EN
    input  logic                 is_signed,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int H = WIDTH / 2;

    if (((WIDTH % 2) != 0) || (WIDTH < 8)) begin : g_bad_width
        $error("karatsuba_mult_pipe: WIDTH must be even and >= 8");
    end

    typedef logic [H-1:0]         half_t;
    typedef logic [H:0]           hsum_t;
    typedef logic [WIDTH-1:0]     word_t;
    typedef logic [WIDTH+1:0]     z1_t;
    typedef logic [2*WIDTH-1:0]   dword_t;

    // ------------------------------------------------------------------
    // Flow control: every stage moves on the same condition, so bubbles
    // are kept and latency stays constant.
    // ------------------------------------------------------------------
    logic adv;
    logic v1_q, v2_q, out_valid_q;
    logic v1_d;

    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign v1_d      = in_valid && adv;

    // ------------------------------------------------------------------
    // Operand conditioning: magnitudes in the signed build, pass-through
    // otherwise. -2^(WIDTH-1) negates to itself, which read unsigned is
    // exactly its magnitude.
    // ------------------------------------------------------------------
    word_t xa, ya;
    logic  neg_d;

`ifdef KMUL_SIGNED_EN
    always_comb begin
        xa    = x;
        ya    = y;
        neg_d = 1'b0;
        if (is_signed) begin
            if (x[WIDTH-1]) xa = -x;
            if (y[WIDTH-1]) ya = -y;
            neg_d = x[WIDTH-1] ^ y[WIDTH-1];
        end
    end
`else
    assign xa    = x;
    assign ya    = y;
    assign neg_d = 1'b0;
`endif

    // ------------------------------------------------------------------
    // S1: split and pre-add. Sums keep their carry (H+1 bits).
    // ------------------------------------------------------------------
    half_t xl_d, xh_d, yl_d, yh_d;
    hsum_t sx_d, sy_d;
    half_t xl_q, xh_q, yl_q, yh_q;
    hsum_t sx_q, sy_q;

    always_comb begin
        xl_d = xa[H-1:0];
        xh_d = xa[WIDTH-1:H];
        yl_d = ya[H-1:0];
        yh_d = ya[WIDTH-1:H];
        sx_d = {1'b0, xl_d} + {1'b0, xh_d};
        sy_d = {1'b0, yl_d} + {1'b0, yh_d};
    end

    // ------------------------------------------------------------------
    // S2: three half-width products. (H+1)x(H+1) needs WIDTH+2 bits.
    // ------------------------------------------------------------------
    word_t z0_d, z2_d;
    z1_t   z1_d;
    word_t z0_q, z2_q;
    z1_t   z1_q;

    always_comb begin
        z0_d = word_t'(xl_q) * word_t'(yl_q);
        z2_d = word_t'(xh_q) * word_t'(yh_q);
        z1_d = z1_t'(sx_q) * z1_t'(sy_q);
    end

    // ------------------------------------------------------------------
    // S3: recombine. mid = xl*yh + xh*yl, so it is never negative. The
    // exact product is below 2^(2*WIDTH), so summing modulo 2^(2*WIDTH)
    // loses nothing.
    // ------------------------------------------------------------------
    z1_t    mid;
    dword_t mag;
    dword_t product_d;
    dword_t product_q;
    logic   neg1_q, neg2_q;

    always_comb begin
        mid       = z1_q - z1_t'(z2_q) - z1_t'(z0_q);
        mag       = (dword_t'(z2_q) << WIDTH) + (dword_t'(mid) << H) + dword_t'(z0_q);
        product_d = neg2_q ? -mag : mag;
    end

    assign product = product_q;

    // Control and product: reset so the output is clean while idle.
    // product only loads with a real result so it never shows stale S2 data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            product_q   <= '0;
        end else if (adv) begin
            v1_q        <= v1_d;
            v2_q        <= v1_q;
            out_valid_q <= v2_q;
            if (v2_q) begin
                product_q <= product_d;
            end
        end
    end

    // Datapath registers need no reset: their contents are qualified by
    // the valid bits above.
    always_ff @(posedge clk) begin
        if (adv) begin
            xl_q   <= xl_d;
            xh_q   <= xh_d;
            yl_q   <= yl_d;
            yh_q   <= yh_d;
            sx_q   <= sx_d;
            sy_q   <= sy_d;
            neg1_q <= neg_d;
            z0_q   <= z0_d;
            z2_q   <= z2_d;
            z1_q   <= z1_d;
            neg2_q <= neg1_q;
        end
    end

endmodule

// File: tb/tb_karatsuba_mult_pipe.sv
// Purpose : self-checking bench for karatsuba_mult_pipe (WIDTH=64, plus WIDTH=8 signed build).
// Latency : expects out_valid in the third cycle after the handshake cycle when unstalled.
// Backpr. : exercises out_ready stalls; scoreboard detects loss, duplication and reordering.
module tb_karatsuba_mult_pipe;

    localparam int W = 64;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     x;
    logic [W-1:0]     y;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   product;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;

    logic [127:0] exp_q[$];
    logic [127:0] last_prod;
    logic         held_v;
    logic [127:0] held_p;

`ifdef KMUL_SIGNED_EN
    logic         is_signed_main;
    logic         in_valid8, in_ready8, is_signed8, out_valid8, out_ready8;
    logic [7:0]   x8, y8;
    logic [15:0]  product8;
`endif

    karatsuba_mult_pipe #(.WIDTH(W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
`ifdef KMUL_SIGNED_EN
        .is_signed (is_signed_main),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

`ifdef KMUL_SIGNED_EN
    karatsuba_mult_pipe #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .x         (x8),
        .y         (y8),
        .is_signed (is_signed8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .product   (product8)
    );
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [127:0] model(input logic [63:0] a, input logic [63:0] b);
        logic [127:0] wa, wb;
        wa = {64'd0, a};
        wb = {64'd0, b};
        return wa * wb;
    endfunction

    // Present one operand pair and hold it until the handshake; the expected
    // result is queued in the cycle the handshake is seen.
    task automatic issue(input logic [63:0] a, input logic [63:0] b);
        logic ok;
        ok       = 1'b0;
        x        = a;
        y        = b;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(a, b));
                ok = 1'b1;
            end
        end
        chk("issue_accept", ok, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    // Output monitor: scoreboard compare on every transfer, plus stability
    // of product while the consumer stalls.
    always @(negedge clk) begin
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (out_valid && !out_ready) begin
                if (held_v) chk("hold_stable", product, held_p);
                held_v = 1'b1;
                held_p = product;
            end else begin
                held_v = 1'b0;
            end
            if (out_valid && out_ready) begin
                chk("sb_has_entry", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    chk("product", product, exp_q.pop_front());
                    last_prod = product;
                    n_out++;
                end
            end
        end
    end

`ifdef KMUL_SIGNED_EN
    task automatic sgn_op(input logic s, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] e);
        logic got;
        is_signed8 = s;
        x8         = a;
        y8         = b;
        in_valid8  = 1'b1;
        @(negedge clk);
        chk("sgn_in_ready", in_ready8, 1);
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (out_valid8) got = 1'b1;
        end
        chk("sgn_valid", got, 1);
        chk("sgn_product", product8, e);
    endtask
`endif

    initial begin
        int out_snap;
        clk       = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        x         = '0;
        y         = '0;
        out_ready = 1'b1;
        held_v    = 1'b0;
        held_p    = '0;
        last_prod = '0;
`ifdef KMUL_SIGNED_EN
        is_signed_main = 1'b0;
        in_valid8      = 1'b0;
        is_signed8     = 1'b0;
        x8             = '0;
        y8             = '0;
        out_ready8     = 1'b1;
`endif

        // Reset / idle
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_product", product, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        #2;
        chk("rel_out_valid", out_valid, 0);
        chk("rel_product", product, 0);
        chk("rel_in_ready", in_ready, 1);

        // Single all-ones op: valid in the third cycle after the handshake
        @(posedge clk);
        #1;
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        chk("lat_c1", out_valid, 0);
        @(negedge clk);
        chk("lat_c2", out_valid, 0);
        @(negedge clk);
        chk("lat_c3", out_valid, 1);
        chk("ones_product", product, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        drain("drain_single");

        // Back-to-back stream with the consumer always ready
        out_snap = n_out;
        for (int k = 0; k < 100; k++) issue({$urandom, $urandom}, {$urandom, $urandom});
        issue(64'd0, 64'd12345);
        issue(64'd1, {$urandom, $urandom});
        issue(64'h1_0000_0000, 64'h1_0000_0000);
        drain("drain_b2b");
        chk("b2b_count", n_out - out_snap, 103);
        chk("b2b_last", last_prod, 128'h1_0000_0000_0000_0000);

        // Backpressure: consumer stalls 4 cycles mid-stream
        out_snap = n_out;
        fork
            begin
                for (int k = 0; k < 10; k++) issue({$urandom, $urandom}, {$urandom, $urandom});
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_out_valid", out_valid, 1);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("drain_stall");
        chk("stall_count", n_out - out_snap, 10);

        // Reset with three operations in flight
        issue(64'd3, 64'd5);
        issue(64'd7, 64'd11);
        issue(64'd13, 64'd17);
        chk("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        exp_q.delete();
        out_snap = n_out;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("no_stale", n_out, out_snap);
        chk("no_stale_valid", out_valid, 0);

        issue(64'hDEAD_BEEF, 64'h1234_5678_9ABC);
        drain("drain_post_rst");

`ifdef KMUL_SIGNED_EN
        sgn_op(1'b1, 8'h80, 8'h80, 16'h4000);
        sgn_op(1'b1, 8'hFF, 8'h02, 16'hFFFE);
        sgn_op(1'b0, 8'hFF, 8'h02, 16'h01FE);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
